// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder built from three enabled shift registers.
// Loads operands, shifts WIDTH times forming sum bits via an internal carry flop.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     a_sout,
  input  logic                     b_sout,
  output logic                     sr_en,
  output logic                     sr_mode,
  output logic                     sum_bit,
  output logic                     cout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, state_nxt;
  logic   carry;
  logic   carry_new;

  assign carry_new = (a_sout & b_sout) | (a_sout & carry) | (b_sout & carry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt holds at LAST on the final shift so it never leaves 0..WIDTH-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry   <= 1'b0;
      cout    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          carry   <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          carry <= carry_new;
          if (bit_cnt == LAST) cout <= carry_new;
          else                 bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sr_en   = 1'b0;
    sr_mode = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    sum_bit = 1'b0;
    case (state)
      LOAD: begin
        sr_en = 1'b1;
        busy  = 1'b1;
      end
      SHIFT: begin
        sr_en   = 1'b1;
        sr_mode = 1'b1;
        busy    = 1'b1;
        sum_bit = a_sout ^ b_sout ^ carry;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with behavioural A/B/SUM shift registers
// around an 8-bit and a 4-bit instance.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start4;
  logic       a_sout, b_sout, a4_sout, b4_sout;
  logic       sr_en, sr_mode, sum_bit, cout, busy, done;
  logic       sr_en4, sr_mode4, sum_bit4, cout4, busy4, done4;
  logic [2:0] bit_cnt;
  logic [1:0] bit_cnt4;

  logic [7:0] a_par, b_par, a_reg, b_reg, s_reg;
  logic [3:0] a4_par, b4_par, a4_reg, b4_reg, s4_reg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a_sout(a_sout), .b_sout(b_sout),
    .sr_en(sr_en), .sr_mode(sr_mode), .sum_bit(sum_bit), .cout(cout),
    .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_sout(a4_sout), .b_sout(b4_sout),
    .sr_en(sr_en4), .sr_mode(sr_mode4), .sum_bit(sum_bit4), .cout(cout4),
    .busy(busy4), .done(done4), .bit_cnt(bit_cnt4)
  );

  // Operand registers shift in 1s (A) / 0s (B) so a stale a_sout is visible after an add
  assign a_sout  = a_reg[0];
  assign b_sout  = b_reg[0];
  assign a4_sout = a4_reg[0];
  assign b4_sout = b4_reg[0];

  always @(posedge clk) begin
    if (sr_en) begin
      if (!sr_mode) begin
        a_reg <= a_par; b_reg <= b_par; s_reg <= 8'h5A;
      end else begin
        a_reg <= {1'b1, a_reg[7:1]};
        b_reg <= {1'b0, b_reg[7:1]};
        s_reg <= {sum_bit, s_reg[7:1]};
      end
    end
    if (sr_en4) begin
      if (!sr_mode4) begin
        a4_reg <= a4_par; b4_reg <= b4_par; s4_reg <= 4'h5;
      end else begin
        a4_reg <= {1'b1, a4_reg[3:1]};
        b4_reg <= {1'b0, b4_reg[3:1]};
        s4_reg <= {sum_bit4, s4_reg[3:1]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic seen);
    a_par = a; b_par = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (done) seen = 1'b1;
      else begin tick(); lat++; end
    end
  endtask

  task automatic check_add(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_cout);
    int lat; logic seen;
    run_add(a, b, lat, seen);
    tests++;
    if (!seen) begin
      fails++; $display("FAIL %s_timeout: done not seen within %0d edges", name, lat);
    end else begin
      tests++;
      if (lat !== 10) begin fails++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end
      tests++;
      if (s_reg !== exp_sum) begin fails++; $display("FAIL %s_sum: got %h expected %h", name, s_reg, exp_sum); end
      tests++;
      if (cout !== exp_cout) begin fails++; $display("FAIL %s_cout: got %b expected %b", name, cout, exp_cout); end
      tests++;
      if ({sr_en, busy, sum_bit} !== 3'b000) begin
        fails++; $display("FAIL %s_done_outs: sr_en/busy/sum_bit got %b expected 000", name, {sr_en, busy, sum_bit});
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start4 = 1'b0;
    a_par = '0; b_par = '0; a4_par = '0; b4_par = '0;
    a_reg = 8'hFF; b_reg = '0; s_reg = '0; a4_reg = '0; b4_reg = '0; s4_reg = '0;
    tick(); tick();
    tests++;
    if ({sr_en, sr_mode, busy, done, cout, sum_bit, bit_cnt} !== 9'b0) begin
      fails++; $display("FAIL reset_outs: got %b expected 000000000",
                        {sr_en, sr_mode, busy, done, cout, sum_bit, bit_cnt});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    check_add("add_92_25", 8'h92, 8'h25, 8'hB7, 1'b0);
  endtask

  task automatic test_carry_clear();
    check_add("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    check_add("add_01_01", 8'h01, 8'h01, 8'h02, 1'b0);
  endtask

  task automatic test_start_ignored();
    int n; int dones; logic [7:0] sum_cap; logic hit;
    a_par = 8'h92; b_par = 8'h25; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0; n = 0;
    while (!hit && n < 20) begin
      if (busy && sr_mode && bit_cnt == 3'd3) hit = 1'b1;
      else begin tick(); n++; end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL ign_reach_bit3: got no SHIFT with bit_cnt=3 expected one"); end
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; sum_cap = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dones++; sum_cap = s_reg; end
      tick();
    end
    tests++;
    if (dones !== 1) begin fails++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    tests++;
    if (sum_cap !== 8'hB7) begin fails++; $display("FAIL ign_sum: got %h expected b7", sum_cap); end
  endtask

  task automatic test_reset_mid_add();
    int n; logic hit; logic [7:0] dummy;
    check_add("pre_rst_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    a_par = 8'h92; b_par = 8'h25; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0; n = 0;
    while (!hit && n < 20) begin
      if (busy && sr_mode && bit_cnt == 3'd4) hit = 1'b1;
      else begin tick(); n++; end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL rst_reach_bit4: got no SHIFT with bit_cnt=4 expected one"); end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({sr_en, sr_mode, busy, done, cout, sum_bit, bit_cnt} !== 9'b0) begin
      fails++; $display("FAIL rst_async_outs: got %b expected 000000000",
                        {sr_en, sr_mode, busy, done, cout, sum_bit, bit_cnt});
    end
    tick();
    reset = 1'b0;
    tick();
    dummy = 8'h00;
    check_add("post_rst_92_25", 8'h92, 8'h25, 8'hB7, dummy[0]);
  endtask

  task automatic test_back_to_back();
    int t; int first; int second; int idle_bad;
    first = -1; second = -1; idle_bad = 0;
    a_par = 8'h10; b_par = 8'h20; start = 1'b1;
    for (t = 1; t < 60 && second < 0; t++) begin
      tick();
      if (!busy && sr_en) idle_bad++;
      if (done) begin
        if (first < 0) first = t; else second = t;
      end
    end
    tests++;
    if (second < 0) begin
      fails++; $display("FAIL b2b_two_dones: got first=%0d second=%0d expected two pulses", first, second);
    end else begin
      tests++;
      if (second - first !== 11) begin fails++; $display("FAIL b2b_period: got %0d expected 11", second - first); end
    end
    tests++;
    if (idle_bad !== 0) begin fails++; $display("FAIL b2b_sr_en_idle: got %0d cycles with sr_en high while idle expected 0", idle_bad); end
    tick();
    tests++;
    if (sr_en !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_idle_after_done: sr_en/busy got %b%b expected 00", sr_en, busy);
    end
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_width4();
    int lat; logic seen;
    a4_par = 4'hF; b4_par = 4'hF; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 30) begin
      if (done4) seen = 1'b1;
      else begin tick(); lat++; end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL w4_timeout: done not seen within %0d edges", lat);
    end else begin
      tests++;
      if (lat !== 6) begin fails++; $display("FAIL w4_latency: got %0d expected 6", lat); end
      tests++;
      if (s4_reg !== 4'hE) begin fails++; $display("FAIL w4_sum: got %h expected e", s4_reg); end
      tests++;
      if (cout4 !== 1'b1) begin fails++; $display("FAIL w4_cout: got %b expected 1", cout4); end
      tests++;
      if (bit_cnt4 !== 2'd3) begin fails++; $display("FAIL w4_bit_cnt_hold: got %0d expected 3", bit_cnt4); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_clear();
    test_start_ignored();
    test_reset_mid_add();
    test_back_to_back();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
